// File: rtl/load_store_unit.sv
// Load/store responder: accepts one request from the control unit and runs a single
// Wishbone-classic cycle with byte-lane steering, load extension, misalignment and timeout handling.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_WIDTH     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cyc,
  input  logic [1:0]            memory_operation,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           store_data,
  output logic                  ack,
  output logic                  data_valid,
  output logic [31:0]           load_data,
  output logic                  misaligned_err,
  output logic                  bus_err,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [31:0]           wb_dat_o,
  output logic [3:0]            wb_sel_o,
  input  logic [31:0]           wb_dat_i,
  input  logic                  wb_ack_i
);

  localparam logic [1:0] MEM_NONE   = 2'd0;
  localparam logic [1:0] LOAD_DATA  = 2'd1;
  localparam logic [1:0] STORE_DATA = 2'd2;

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {IDLE, BUS, LD_DONE, HOLD, ERR} state_t;

  state_t          state_q, state_d;
  logic            is_load_q, is_load_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [1:0]      lane_q, lane_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            ack_d, data_valid_d, misaligned_err_d, bus_err_d;
  logic            bus_d, we_d;
  logic [31:0]     load_data_d, dat_d;
  logic [ADDR_WIDTH-1:0] adr_d;
  logic [3:0]      sel_d;

  logic            req_valid, req_load, f3_legal, misaligned, timeout_hit;
  logic [31:0]     store_repl;
  logic [3:0]      sel_req;

  function automatic logic [31:0] extend(input logic [31:0] w, input logic [2:0] f3,
                                         input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lane[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  extend = {{24{b[7]}}, b};
      3'b001:  extend = {{16{h[15]}}, h};
      3'b100:  extend = {24'd0, b};
      3'b101:  extend = {16'd0, h};
      default: extend = w;
    endcase
  endfunction

  // Decode of the incoming request; only consulted in IDLE.
  always_comb begin
    req_valid = cyc && (memory_operation == LOAD_DATA || memory_operation == STORE_DATA);
    req_load  = (memory_operation == LOAD_DATA);
    if (req_load)
      f3_legal = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    else
      f3_legal = funct3 inside {3'b000, 3'b001, 3'b010};
    misaligned = (funct3[1:0] == 2'b01 && address[0]) ||
                 (funct3[1:0] == 2'b10 && address[1:0] != 2'b00);
    case (funct3[1:0])
      2'b00: begin
        store_repl = {4{store_data[7:0]}};
        sel_req    = 4'b0001 << address[1:0];
      end
      2'b01: begin
        store_repl = {2{store_data[15:0]}};
        sel_req    = address[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        store_repl = store_data;
        sel_req    = 4'b1111;
      end
    endcase
    timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q + CW'(1) == TO_LIMIT);
  end

  always_comb begin
    state_d          = state_q;
    is_load_d        = is_load_q;
    funct3_d         = funct3_q;
    lane_d           = lane_q;
    rdata_d          = rdata_q;
    cnt_d            = cnt_q;
    ack_d            = ack;
    data_valid_d     = 1'b0;
    misaligned_err_d = 1'b0;
    bus_err_d        = 1'b0;
    load_data_d      = load_data;
    bus_d            = wb_cyc_o;
    we_d             = wb_we_o;
    adr_d            = wb_adr_o;
    dat_d            = wb_dat_o;
    sel_d            = wb_sel_o;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          is_load_d = req_load;
          funct3_d  = funct3;
          lane_d    = address[1:0];
          cnt_d     = '0;
          if (misaligned || !f3_legal) begin
            state_d          = ERR;
            misaligned_err_d = 1'b1;
            ack_d            = 1'b1;
            load_data_d      = '0;
          end else begin
            state_d = BUS;
            bus_d   = 1'b1;
            we_d    = !req_load;
            adr_d   = {address[ADDR_WIDTH-1:2], 2'b00};
            dat_d   = store_repl;
            sel_d   = sel_req;
            ack_d   = req_load;
          end
        end
      end
      BUS: begin
        if (wb_ack_i) begin
          bus_d   = 1'b0;
          we_d    = 1'b0;
          rdata_d = wb_dat_i;
          ack_d   = 1'b1;
          state_d = is_load_q ? LD_DONE : HOLD;
        end else if (timeout_hit) begin
          // An abandoned access completes with a zero result so the requester never stalls.
          bus_d       = 1'b0;
          we_d        = 1'b0;
          bus_err_d   = 1'b1;
          ack_d       = 1'b1;
          load_data_d = '0;
          state_d     = HOLD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      LD_DONE: begin
        if (!cyc) begin
          data_valid_d = 1'b1;
          load_data_d  = extend(rdata_q, funct3_q, lane_q);
          ack_d        = 1'b0;
          state_d      = IDLE;
        end
      end
      HOLD, ERR: begin
        if (!cyc) begin
          ack_d        = 1'b0;
          data_valid_d = is_load_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      is_load_q      <= 1'b0;
      funct3_q       <= '0;
      lane_q         <= '0;
      rdata_q        <= '0;
      cnt_q          <= '0;
      ack            <= 1'b0;
      data_valid     <= 1'b0;
      load_data      <= '0;
      misaligned_err <= 1'b0;
      bus_err        <= 1'b0;
      wb_cyc_o       <= 1'b0;
      wb_we_o        <= 1'b0;
      wb_adr_o       <= '0;
      wb_dat_o       <= '0;
      wb_sel_o       <= '0;
    end else begin
      state_q        <= state_d;
      is_load_q      <= is_load_d;
      funct3_q       <= funct3_d;
      lane_q         <= lane_d;
      rdata_q        <= rdata_d;
      cnt_q          <= cnt_d;
      ack            <= ack_d;
      data_valid     <= data_valid_d;
      load_data      <= load_data_d;
      misaligned_err <= misaligned_err_d;
      bus_err        <= bus_err_d;
      wb_cyc_o       <= bus_d;
      wb_we_o        <= we_d;
      wb_adr_o       <= adr_d;
      wb_dat_o       <= dat_d;
      wb_sel_o       <= sel_d;
    end
  end

  assign wb_stb_o = wb_cyc_o;

endmodule
